// File: rtl/i2c_byte_master.sv
// -----------------------------------------------------------------------------
// i2c_byte_master
//
// Byte-level I2C bus initiator. Each accepted command produces an optional
// START (or repeated START when issued from HOLD), eight data bits MSB first,
// one ACK bit and an optional STOP. The bus is driven only through pull-down
// enables; a released line is pulled high externally.
//
// Parameters
//   QUARTER       clock cycles per quarter SCL period (2..65535)
//
// Ports
//   clock         system clock, rising edge
//   reset_n       asynchronous active-low reset
//   cmd_valid     command present
//   cmd_ready     block can accept a command (IDLE or HOLD)
//   cmd_start     precede byte with START / repeated START (forced in IDLE)
//   cmd_stop      follow byte with STOP
//   cmd_read      1 = receive a byte, 0 = transmit tx_byte
//   cmd_ack       read only: 1 = master ACKs the byte, 0 = NACK
//   tx_byte       byte to transmit, MSB first
//   done          one-cycle pulse when a command completes
//   rx_byte       received byte, valid from done until the next done
//   ack_received  write only: 1 = slave ACKed, valid from done
//   busy          block is not IDLE
//   SCL_in/SDA_in raw bus levels
//   SCL_pd/SDA_pd 1 = pull line low, 0 = release
//
// Build option
//   I2C_MASTER_STRETCH_EN  when defined, high phases of BIT_HIGH, ACK_HIGH and
//                          STOP_SETUP do not start counting until the
//                          synchronized SCL reads high (slave clock stretching).
// -----------------------------------------------------------------------------
`default_nettype none

module i2c_byte_master #(
    parameter int unsigned QUARTER = 16'd25
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_start,
    input  logic       cmd_stop,
    input  logic       cmd_read,
    input  logic       cmd_ack,
    input  logic [7:0] tx_byte,
    output logic       done,
    output logic [7:0] rx_byte,
    output logic       ack_received,
    output logic       busy,
    input  logic       SCL_in,
    input  logic       SDA_in,
    output logic       SCL_pd,
    output logic       SDA_pd
);

    localparam logic [15:0] QM1 = 16'(QUARTER - 1);

    typedef enum logic [3:0] {
        IDLE,
        START_SETUP,
        START_HOLD,
        BIT_LOW,
        BIT_HIGH,
        ACK_LOW,
        ACK_HIGH,
        STOP_LOW,
        STOP_SETUP,
        STOP_HOLD,
        HOLD
    } state_t;

    state_t      state;
    logic [1:0]  scl_sync;
    logic [1:0]  sda_sync;
    logic        scl_s;
    logic        sda_s;
    logic [15:0] phase_cnt;    // counts 0..Q-1 within one quarter
    logic        phase_half;   // 0 = first quarter of a phase, 1 = second
    logic [2:0]  bit_cnt;
    logic [2:0]  next_bit;
    logic [7:0]  rx_shift;
    logic [7:0]  lat_tx;
    logic        lat_read;
    logic        lat_ack;
    logic        lat_stop;
    logic        rs_low;       // repeated START: SCL still held low
    logic        accept;
    logic        eff_start;
    logic        quarter_end;
    logic        phase_end;
    logic        sample_pt;
    logic        stretch_hold;

    // Both synchronizer flops reset to 1 so an idle bus reads high.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
        end else begin
            scl_sync <= {scl_sync[0], SCL_in};
            sda_sync <= {sda_sync[0], SDA_in};
        end
    end

    assign scl_s = scl_sync[1];
    assign sda_s = sda_sync[1];

    assign cmd_ready   = (state == IDLE) || (state == HOLD);
    assign busy        = (state != IDLE);
    assign accept      = cmd_valid && cmd_ready;
    assign eff_start   = (state == IDLE) ? 1'b1 : cmd_start;

    // A phase is two quarters, so the 16-bit counter never has to hold 2Q.
    assign quarter_end = (phase_cnt == QM1);
    assign phase_end   = quarter_end && phase_half;
    assign sample_pt   = quarter_end && !phase_half;
    assign next_bit    = bit_cnt - 3'd1;

`ifdef I2C_MASTER_STRETCH_EN
    assign stretch_hold = ((state == BIT_HIGH) || (state == ACK_HIGH) ||
                           (state == STOP_SETUP)) && !scl_s;
`else
    logic scl_s_unused;
    assign scl_s_unused = scl_s;
    assign stretch_hold = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            phase_cnt    <= 16'd0;
            phase_half   <= 1'b0;
            bit_cnt      <= 3'd7;
            rx_shift     <= 8'h00;
            lat_tx       <= 8'h00;
            lat_read     <= 1'b0;
            lat_ack      <= 1'b0;
            lat_stop     <= 1'b0;
            rs_low       <= 1'b0;
            SCL_pd       <= 1'b0;
            SDA_pd       <= 1'b0;
            done         <= 1'b0;
            rx_byte      <= 8'h00;
            ack_received <= 1'b0;
        end else begin
            done <= 1'b0;

            // Phase timing; wraps to 0 at the end of every phase.
            if (stretch_hold) begin
                phase_cnt  <= 16'd0;
                phase_half <= 1'b0;
            end else if (quarter_end) begin
                phase_cnt  <= 16'd0;
                phase_half <= ~phase_half;
            end else begin
                phase_cnt  <= phase_cnt + 16'd1;
            end

            case (state)
                IDLE, HOLD: begin
                    phase_cnt  <= 16'd0;
                    phase_half <= 1'b0;
                    if (accept) begin
                        lat_tx   <= tx_byte;
                        lat_read <= cmd_read;
                        lat_ack  <= cmd_ack;
                        lat_stop <= cmd_stop;
                        bit_cnt  <= 3'd7;
                        if (eff_start) begin
                            state  <= START_SETUP;
                            SDA_pd <= 1'b0;
                            // From HOLD SCL is low and must stay low first.
                            rs_low <= (state == HOLD);
                        end else begin
                            // Continue straight into the next byte, SCL already low.
                            state  <= BIT_LOW;
                            SCL_pd <= 1'b1;
                            SDA_pd <= cmd_read ? 1'b0 : ~tx_byte[7];
                        end
                    end
                end

                START_SETUP: begin
                    if (phase_end) begin
                        if (rs_low) begin
                            rs_low <= 1'b0;
                            SCL_pd <= 1'b0;
                        end else begin
                            state  <= START_HOLD;
                            SDA_pd <= 1'b1;
                        end
                    end
                end

                START_HOLD: begin
                    if (phase_end) begin
                        state  <= BIT_LOW;
                        SCL_pd <= 1'b1;
                        SDA_pd <= lat_read ? 1'b0 : ~lat_tx[7];
                    end
                end

                BIT_LOW: begin
                    if (phase_end) begin
                        state  <= BIT_HIGH;
                        SCL_pd <= 1'b0;
                    end
                end

                BIT_HIGH: begin
                    if (sample_pt) begin
                        rx_shift[bit_cnt] <= sda_s;
                    end
                    if (phase_end) begin
                        SCL_pd <= 1'b1;
                        if (bit_cnt == 3'd0) begin
                            state  <= ACK_LOW;
                            SDA_pd <= lat_read ? lat_ack : 1'b0;
                        end else begin
                            state   <= BIT_LOW;
                            bit_cnt <= next_bit;
                            SDA_pd  <= lat_read ? 1'b0 : ~lat_tx[next_bit];
                        end
                    end
                end

                ACK_LOW: begin
                    if (phase_end) begin
                        state  <= ACK_HIGH;
                        SCL_pd <= 1'b0;
                    end
                end

                ACK_HIGH: begin
                    if (sample_pt && !lat_read) begin
                        ack_received <= ~sda_s;
                    end
                    if (phase_end) begin
                        SCL_pd <= 1'b1;
                        if (lat_read) begin
                            rx_byte <= rx_shift;
                        end
                        if (lat_stop) begin
                            state  <= STOP_LOW;
                            SDA_pd <= 1'b1;
                        end else begin
                            state  <= HOLD;
                            SDA_pd <= 1'b0;
                            done   <= 1'b1;
                        end
                    end
                end

                STOP_LOW: begin
                    if (phase_end) begin
                        state  <= STOP_SETUP;
                        SCL_pd <= 1'b0;
                    end
                end

                STOP_SETUP: begin
                    if (phase_end) begin
                        state  <= STOP_HOLD;
                        SDA_pd <= 1'b0;
                    end
                end

                STOP_HOLD: begin
                    if (phase_end) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end

                default: begin
                    state  <= IDLE;
                    SCL_pd <= 1'b0;
                    SDA_pd <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_i2c_byte_master.sv
// -----------------------------------------------------------------------------
// tb_i2c_byte_master
//
// Directed bench for i2c_byte_master with QUARTER = 4. An open-drain bus model
// combines the master pull-downs with a small behavioural slave that ACKs,
// NACKs or sends a byte, and detects START/STOP conditions on the bus.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_i2c_byte_master;

    localparam int Q = 4;
`ifdef I2C_MASTER_STRETCH_EN
    localparam int SX = 2;
`else
    localparam int SX = 0;
`endif
    localparam int HIGH_RUN = 2 * Q + SX;
    localparam int LAT_SS   = 46 * Q + 1 + 10 * SX;   // START + byte + STOP
    localparam int LAT_NS   = 40 * Q + 1 + 9 * SX;    // START + byte, no STOP
    localparam int LAT_RS   = 48 * Q + 1 + 10 * SX;   // repeated START + byte + STOP

    logic       clock = 1'b0;
    logic       reset_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_start;
    logic       cmd_stop;
    logic       cmd_read;
    logic       cmd_ack;
    logic [7:0] tx_byte;
    logic       done;
    logic [7:0] rx_byte;
    logic       ack_received;
    logic       busy;
    logic       SCL_in;
    logic       SDA_in;
    logic       SCL_pd;
    logic       SDA_pd;

    logic       slave_sda = 1'b0;
    logic       slave_scl_hold = 1'b0;
    int         slave_mode = 0;      // 0 write+ACK, 1 read, 2 write+NACK
    logic [7:0] slave_tx = 8'h00;

    assign SCL_in = !(SCL_pd || slave_scl_hold);
    assign SDA_in = !(SDA_pd || slave_sda);

    always #5 clock = ~clock;

    i2c_byte_master #(.QUARTER(Q)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_start    (cmd_start),
        .cmd_stop     (cmd_stop),
        .cmd_read     (cmd_read),
        .cmd_ack      (cmd_ack),
        .tx_byte      (tx_byte),
        .done         (done),
        .rx_byte      (rx_byte),
        .ack_received (ack_received),
        .busy         (busy),
        .SCL_in       (SCL_in),
        .SDA_in       (SDA_in),
        .SCL_pd       (SCL_pd),
        .SDA_pd       (SDA_pd)
    );

    // ---------------- bus-level slave model ----------------
    int         fall_cnt = 0;
    int         start_mark = 0;
    int         start_cnt = 0;
    int         stop_cnt = 0;
    int         slave_k = 0;
    logic       mst_bit [1:9];
    logic [7:0] slave_rx = 8'h00;

    always @(negedge SDA_in) begin
        #0.1;
        if (SCL_in && !SDA_in) begin
            start_cnt++;
            start_mark = fall_cnt;
        end
    end

    always @(posedge SDA_in) begin
        #0.1;
        if (SCL_in && SDA_in) stop_cnt++;
    end

    // Cell k (1..8 data, 9 ACK) begins with the k-th SCL fall after START.
    always @(negedge SCL_in) begin
        fall_cnt++;
        slave_k = fall_cnt - start_mark;
        if (slave_mode == 1) begin
            if (slave_k >= 1 && slave_k <= 8) slave_sda = ~slave_tx[8 - slave_k];
            else slave_sda = 1'b0;
        end else if (slave_mode == 0 && slave_k == 9) begin
            slave_sda = 1'b1;
        end else begin
            slave_sda = 1'b0;
        end
    end

    always @(posedge SCL_in) begin
        int k;
        k = fall_cnt - start_mark;
        if (k >= 1 && k <= 9) mst_bit[k] = SDA_pd;
        if (k >= 1 && k <= 8) slave_rx = {slave_rx[6:0], SDA_in};
    end

    // ---------------- cycle monitor ----------------
    int cyc_now = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int run = 0;
    int high_runs [$];

    always @(posedge clock) begin
        #1;
        cyc_now++;
        if (done) begin
            done_cnt++;
            done_cyc = cyc_now;
        end
        if (!SCL_pd) begin
            run++;
        end else begin
            if (run > 0) high_runs.push_back(run);
            run = 0;
        end
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    int acc_cyc, d0, hr_base, st0, sp0;

    task automatic issue(input logic st, input logic sp, input logic rd,
                         input logic ak, input logic [7:0] tx);
        @(negedge clock);
        cmd_start = st;
        cmd_stop  = sp;
        cmd_read  = rd;
        cmd_ack   = ak;
        tx_byte   = tx;
        cmd_valid = 1'b1;
        acc_cyc   = cyc_now;
        d0        = done_cnt;
        hr_base   = high_runs.size();
        st0       = start_cnt;
        sp0       = stop_cnt;
        @(negedge clock);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int exp_lat);
        for (int i = 0; i < 3000 && done_cnt == d0; i++) @(negedge clock);
        check_eq({tag, "_latency"}, done_cyc - acc_cyc, exp_lat);
        repeat (3 * Q) @(negedge clock);
        check_eq({tag, "_done_count"}, done_cnt - d0, 1);
    endtask

    logic [7:0] exp_pd;
    int         dsave;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        cmd_start = 1'b0;
        cmd_stop  = 1'b0;
        cmd_read  = 1'b0;
        cmd_ack   = 1'b0;
        tx_byte   = 8'h00;
        repeat (3) @(negedge clock);

        check_eq("rst_scl_pd", SCL_pd, 0);
        check_eq("rst_sda_pd", SDA_pd, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_rx_byte", rx_byte, 8'h00);
        check_eq("rst_ack", ack_received, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_ready", cmd_ready, 1);
        reset_n = 1'b1;
        repeat (3) @(negedge clock);

        // Write 0xA5 with START and STOP, slave ACKs.
        slave_mode = 0;
        issue(1'b1, 1'b1, 1'b0, 1'b0, 8'hA5);
        wait_done("wr_a5", LAT_SS);
        exp_pd = 8'b0101_1010;
        for (int j = 1; j <= 8; j++)
            check_eq($sformatf("wr_a5_sda_pd_cell%0d", j), mst_bit[j], exp_pd[8 - j]);
        check_eq("wr_a5_ack", ack_received, 1);
        check_eq("wr_a5_slave_rx", slave_rx, 8'hA5);
        check_eq("wr_a5_start", start_cnt - st0, 1);
        check_eq("wr_a5_stop", stop_cnt - sp0, 1);
        check_eq("wr_a5_busy", busy, 0);
        check_eq("wr_a5_runs", high_runs.size() >= hr_base + 10, 1);
        if (high_runs.size() >= hr_base + 10)
            for (int j = 1; j <= 9; j++)
                check_eq($sformatf("wr_a5_high%0d", j), high_runs[hr_base + j], HIGH_RUN);

        // Read 0x3C, master NACKs, STOP.
        slave_mode = 1;
        slave_tx   = 8'h3C;
        issue(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
        wait_done("rd_3c", LAT_SS);
        check_eq("rd_3c_rx", rx_byte, 8'h3C);
        check_eq("rd_3c_ack_cell_sda", mst_bit[9], 0);
        check_eq("rd_3c_data_sda", mst_bit[3], 0);
        check_eq("rd_3c_stop", stop_cnt - sp0, 1);
        check_eq("rd_3c_busy", busy, 0);
        check_eq("rd_3c_ready", cmd_ready, 1);

        // Write 0x50 without STOP, then repeated START read 0x96 with ACK.
        slave_mode = 0;
        issue(1'b1, 1'b0, 1'b0, 1'b0, 8'h50);
        wait_done("wr_50", LAT_NS);
        check_eq("wr_50_ack", ack_received, 1);
        check_eq("wr_50_slave_rx", slave_rx, 8'h50);
        repeat (10) @(negedge clock);
        check_eq("hold_scl_pd", SCL_pd, 1);
        check_eq("hold_sda_pd", SDA_pd, 0);
        check_eq("hold_busy", busy, 1);
        check_eq("hold_ready", cmd_ready, 1);
        check_eq("hold_no_stop", stop_cnt - sp0, 0);
        slave_mode = 1;
        slave_tx   = 8'h96;
        issue(1'b1, 1'b1, 1'b1, 1'b1, 8'h00);
        wait_done("rs_rd", LAT_RS);
        check_eq("rs_rd_restart", start_cnt - st0, 1);
        check_eq("rs_rd_rx", rx_byte, 8'h96);
        check_eq("rs_rd_master_ack", mst_bit[9], 1);
        check_eq("rs_rd_stop", stop_cnt - sp0, 1);

`ifdef I2C_MASTER_STRETCH_EN
        // Slave stretches the high phase of bit 3 (cell 5) by 50 cycles.
        slave_mode = 0;
        issue(1'b1, 1'b1, 1'b0, 1'b0, 8'hC3);
        for (int i = 0; i < 2000 && slave_k != 5; i++) @(negedge clock);
        slave_scl_hold = 1'b1;
        for (int i = 0; i < 200 && SCL_pd; i++) begin
            @(posedge clock);
            #1;
        end
        repeat (50) @(posedge clock);
        #1;
        slave_scl_hold = 1'b0;
        wait_done("stretch", LAT_SS + 50);
        check_eq("stretch_runs", high_runs.size() >= hr_base + 10, 1);
        if (high_runs.size() >= hr_base + 10) begin
            check_eq("stretch_bit3_len",
                     (high_runs[hr_base + 5] >= 58) && (high_runs[hr_base + 5] <= 62), 1);
            check_eq("stretch_bit7_len", high_runs[hr_base + 1], HIGH_RUN);
            check_eq("stretch_bit4_len", high_runs[hr_base + 4], HIGH_RUN);
            check_eq("stretch_bit2_len", high_runs[hr_base + 6], HIGH_RUN);
        end
        check_eq("stretch_slave_rx", slave_rx, 8'hC3);
`endif

        // Reset in the middle of bit 5 of a write.
        slave_mode = 0;
        issue(1'b1, 1'b1, 1'b0, 1'b0, 8'hFF);
        for (int i = 0; i < 2000 && slave_k != 3; i++) @(negedge clock);
        repeat (2) @(negedge clock);
        dsave   = done_cnt;
        reset_n = 1'b0;
        #1;
        check_eq("midrst_scl_pd", SCL_pd, 0);
        check_eq("midrst_sda_pd", SDA_pd, 0);
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_ready", cmd_ready, 1);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (20) @(negedge clock);
        check_eq("midrst_no_done", done_cnt - dsave, 0);

        // Command from IDLE with cmd_start = 0 still begins with START.
        issue(1'b0, 1'b1, 1'b0, 1'b0, 8'h81);
        wait_done("post_rst", LAT_SS);
        check_eq("post_rst_start", start_cnt - st0, 1);
        check_eq("post_rst_slave_rx", slave_rx, 8'h81);
        check_eq("post_rst_ack", ack_received, 1);

        // Slave NACKs a write; STOP still completes.
        slave_mode = 2;
        issue(1'b1, 1'b1, 1'b0, 1'b0, 8'h3A);
        wait_done("nack", LAT_SS);
        check_eq("nack_ack", ack_received, 0);
        check_eq("nack_stop", stop_cnt - sp0, 1);
        check_eq("nack_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
